// File: rtl/alu_result_buffer.sv
// alu_result_buffer: FIFO between ALU execute and writeback/bypass arbiter.
// Holds result, flags, dest tag and active-list id; flush drops everything.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   flush_i                  recovery flush, clears all entries
//   in_valid_i / in_ready_o  ALU-side handshake
//   in_result_i, in_flags_i, in_dest_i, in_alid_i   payload in
//   out_valid_o / out_ready_i  writeback-side handshake
//   out_result_o, out_flags_o, out_dest_o, out_alid_o  head payload
//   count_o                  occupied entries
//   byp_valid_o, byp_tag_o, byp_data_o  same-cycle bypass of the pushed
//                            result, only when ALU_RESULT_BYPASS_EN is defined
module alu_result_buffer #(
    parameter int SIZE_DATA           = 32,
    parameter int EXECUTION_FLAGS     = 6,
    parameter int SIZE_PHYSICAL_LOG   = 7,
    parameter int SIZE_ACTIVELIST_LOG = 7,
    parameter int DEPTH               = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [SIZE_DATA-1:0]           in_result_i,
    input  logic [EXECUTION_FLAGS-1:0]     in_flags_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]   in_dest_i,
    input  logic [SIZE_ACTIVELIST_LOG-1:0] in_alid_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [SIZE_DATA-1:0]           out_result_o,
    output logic [EXECUTION_FLAGS-1:0]     out_flags_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]   out_dest_o,
    output logic [SIZE_ACTIVELIST_LOG-1:0] out_alid_o,
`ifdef ALU_RESULT_BYPASS_EN
    output logic                           byp_valid_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]   byp_tag_o,
    output logic [SIZE_DATA-1:0]           byp_data_o,
`endif
    output logic [$clog2(DEPTH):0]         count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = SIZE_DATA + EXECUTION_FLAGS
                           + SIZE_PHYSICAL_LOG + SIZE_ACTIVELIST_LOG;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               push, pop;

    // Readiness looks only at registered occupancy, so a full buffer
    // never accepts even when the head is leaving this cycle.
    assign in_ready_o  = (count_q != FULL);
    assign out_valid_o = (count_q != '0);
    assign count_o     = count_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    assign head = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign {out_result_o, out_flags_o, out_dest_o, out_alid_o} = head;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push && !flush_i && !reset) begin
            mem_q[wr_ptr_q] <= {in_result_i, in_flags_i, in_dest_i, in_alid_i};
        end
    end

`ifdef ALU_RESULT_BYPASS_EN
    assign byp_valid_o = push & ~flush_i & ~reset;
    assign byp_tag_o   = byp_valid_o ? in_dest_i : '0;
    assign byp_data_o  = byp_valid_o ? in_result_i : '0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: table vectors, hand sequences and a randomized
// run against a queue-based model of alu_result_buffer.
module tb_alu_result_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, flush_i, in_valid_i, in_ready_o;
    logic [31:0] in_result_i;
    logic [5:0]  in_flags_i;
    logic [6:0]  in_dest_i, in_alid_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_result_o;
    logic [5:0]  out_flags_o;
    logic [6:0]  out_dest_o, out_alid_o;
    logic [1:0]  count_o;
`ifdef ALU_RESULT_BYPASS_EN
    logic        byp_valid_o;
    logic [6:0]  byp_tag_o;
    logic [31:0] byp_data_o;
`endif

    alu_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_result_i(in_result_i), .in_flags_i(in_flags_i),
        .in_dest_i(in_dest_i), .in_alid_i(in_alid_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_result_o(out_result_o), .out_flags_o(out_flags_o),
        .out_dest_o(out_dest_o), .out_alid_o(out_alid_o),
`ifdef ALU_RESULT_BYPASS_EN
        .byp_valid_o(byp_valid_o), .byp_tag_o(byp_tag_o),
        .byp_data_o(byp_data_o),
`endif
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst, fl, iv;
        logic [31:0] data;
        logic [6:0]  dest, alid;
        logic ordy;
        logic [1:0]  cnt;
        logic vld, rdy;
        logic [31:0] odata;
        logic [6:0]  odest, oalid;
    } vec_t;

    function automatic vec_t mk(input logic rst, fl, iv,
                                input logic [31:0] data,
                                input logic [6:0] dest, alid,
                                input logic ordy,
                                input logic [1:0] cnt,
                                input logic vld, rdy,
                                input logic [31:0] odata,
                                input logic [6:0] odest, oalid);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.data = data;
        v.dest = dest; v.alid = alid; v.ordy = ordy;
        v.cnt = cnt; v.vld = vld; v.rdy = rdy;
        v.odata = odata; v.odest = odest; v.oalid = oalid;
        return v;
    endfunction

    task automatic drive(input logic rst, fl, iv, input logic [31:0] d,
                         input logic [6:0] dest, alid, input logic ordy);
        reset = rst; flush_i = fl; in_valid_i = iv;
        in_result_i = d; in_flags_i = d[5:0];
        in_dest_i = dest; in_alid_i = alid; out_ready_i = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [31:0] r;
        logic [5:0]  f;
        logic [6:0]  d, a;
    } ent_t;

    ent_t model_q[$];

    vec_t vecs[19];
    logic prev_rdy;
    ent_t e, hd;
    logic m_push, m_pop;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;

        vecs[0]  = mk(1,0,0,0,0,0,0, 0,0,1,0,0,0);
        vecs[1]  = mk(1,0,0,0,0,0,0, 0,0,1,0,0,0);
        vecs[2]  = mk(0,0,1,32'h5,12,3,1, 1,1,1,32'h5,12,3);
        vecs[3]  = mk(0,0,0,0,0,0,1, 0,0,1,0,0,0);
        vecs[4]  = mk(0,0,1,32'h11,1,1,0, 1,1,1,32'h11,1,1);
        vecs[5]  = mk(0,0,1,32'h22,2,2,0, 2,1,0,32'h11,1,1);
        vecs[6]  = mk(0,0,1,32'h33,3,3,0, 2,1,0,32'h11,1,1);
        vecs[7]  = mk(0,0,0,0,0,0,1, 1,1,1,32'h22,2,2);
        vecs[8]  = mk(0,0,0,0,0,0,1, 0,0,1,0,0,0);
        vecs[9]  = mk(0,0,1,32'h44,4,4,0, 1,1,1,32'h44,4,4);
        vecs[10] = mk(0,0,1,32'h55,5,5,0, 2,1,0,32'h44,4,4);
        vecs[11] = mk(0,0,1,32'h66,6,6,1, 1,1,1,32'h55,5,5);
        vecs[12] = mk(0,0,0,0,0,0,1, 0,0,1,0,0,0);
        vecs[13] = mk(0,0,1,32'h77,7,7,0, 1,1,1,32'h77,7,7);
        vecs[14] = mk(0,0,1,32'h88,8,8,0, 2,1,0,32'h77,7,7);
        vecs[15] = mk(0,1,1,32'h99,9,9,1, 0,0,1,0,0,0);
        vecs[16] = mk(0,0,0,0,0,0,0, 0,0,1,0,0,0);
        vecs[17] = mk(0,0,1,32'hAA,10,10,0, 1,1,1,32'hAA,10,10);
        vecs[18] = mk(1,0,1,32'hBB,11,11,0, 0,0,1,0,0,0);

        prev_rdy = 1'b0;
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].data,
                  vecs[i].dest, vecs[i].alid, vecs[i].ordy);
`ifdef ALU_RESULT_BYPASS_EN
            #1;
            chk($sformatf("vec%0d byp_valid", i), 64'(byp_valid_o),
                64'(vecs[i].iv & prev_rdy & ~vecs[i].fl & ~vecs[i].rst));
            if (vecs[i].iv & prev_rdy & ~vecs[i].fl & ~vecs[i].rst)
                chk($sformatf("vec%0d byp_tag", i), 64'(byp_tag_o),
                    64'(vecs[i].dest));
`endif
            tick();
            chk($sformatf("vec%0d count", i), 64'(count_o), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d out_valid", i), 64'(out_valid_o),
                64'(vecs[i].vld));
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready_o),
                64'(vecs[i].rdy));
            chk($sformatf("vec%0d result", i), 64'(out_result_o),
                64'(vecs[i].odata));
            chk($sformatf("vec%0d flags", i), 64'(out_flags_o),
                64'(vecs[i].odata[5:0]));
            chk($sformatf("vec%0d dest", i), 64'(out_dest_o),
                64'(vecs[i].odest));
            chk($sformatf("vec%0d alid", i), 64'(out_alid_o),
                64'(vecs[i].oalid));
            prev_rdy = vecs[i].rdy;
        end

        // Streaming push/pop every cycle: 1..10 in order, count held at 1.
        drive(0, 0, 1, 1, 1, 1, 0);
        tick();
        chk("stream prime count", 64'(count_o), 64'd1);
        for (int k = 2; k <= 10; k++) begin
            drive(0, 0, 1, 32'(k), 7'(k), 7'(k), 1);
            #1;
            chk($sformatf("stream out %0d", k - 1), 64'(out_result_o),
                64'(k - 1));
            tick();
            chk($sformatf("stream count %0d", k), 64'(count_o), 64'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("stream out 10", 64'(out_result_o), 64'd10);
        tick();
        chk("stream drained", 64'(count_o), 64'd0);

        // Randomized run against the queue model.
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        model_q.delete();
        for (int c = 0; c < 600; c++) begin
            e.r = $urandom;
            e.f = 6'($urandom);
            e.d = 7'($urandom);
            e.a = 7'($urandom);
            reset = ($urandom_range(0, 99) < 2);
            flush_i = ($urandom_range(0, 99) < 4);
            in_valid_i = ($urandom_range(0, 9) < 6);
            out_ready_i = $urandom_range(0, 1);
            in_result_i = e.r; in_flags_i = e.f;
            in_dest_i = e.d; in_alid_i = e.a;
            #1;
            hd = (model_q.size() != 0) ? model_q[0] : '0;
            chk("rnd count", 64'(count_o), 64'(model_q.size()));
            chk("rnd in_ready", 64'(in_ready_o),
                64'(model_q.size() < DEPTH));
            chk("rnd out_valid", 64'(out_valid_o),
                64'(model_q.size() != 0));
            chk("rnd payload", {out_result_o, out_flags_o, out_dest_o,
                out_alid_o}, 64'(hd));
            m_push = in_valid_i && (model_q.size() < DEPTH);
            m_pop  = out_ready_i && (model_q.size() != 0);
`ifdef ALU_RESULT_BYPASS_EN
            chk("rnd byp_valid", 64'(byp_valid_o),
                64'(m_push & ~flush_i & ~reset));
`endif
            if (reset || flush_i) begin
                model_q.delete();
            end else begin
                if (m_pop)  void'(model_q.pop_front());
                if (m_push) model_q.push_back(e);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
